i2c_master_engine: RTL and testbench

Single-byte I2C master that is the bus-side counterpart of the register-file I2C window.
- Consumes the register-mapped command fields: slave address, sub-address plus go bit, and the transmit byte.
- Runs one complete write or random-read transaction on open-drain SCL/SDA.
- Returns status and the received byte through a write-back strobe.
- Sits between the register file and the board I2C pads (audio codec control path).

---
 rtl/i2c_master_engine.sv | 121 ++++++++++++
 tb/tb_i2c_master_engine.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/i2c_master_engine.sv
// i2c_master_engine: single-byte I2C write / random-read master on open-drain SCL/SDA with register write-back.
// Optional SCL clock stretching in Q1 when I2C_CLK_STRETCH_EN is defined.
module i2c_master_engine #(
  parameter int CLK_DIV = 125
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] slave_addr,
  input  logic [8:0] i2c_addr,
  input  logic [7:0] tx_data,
  output logic       i2c_wr_en,
  output logic [1:0] i2c_sts,
  output logic [7:0] rx_data,
  output logic       scl_oe,
  output logic       sda_oe,
  input  logic       scl_i,
  input  logic       sda_i
);
  typedef enum logic [3:0] {
    IDLE, START, ADDR, ACK_A, SUB, ACK_S, WDATA, ACK_W,
    RSTART, RADDR, ACK_R, RDATA, MACK, STOP, DONE
  } state_e;
  state_e     state_q, state_d;
  logic       go_q, nack_q;
  logic [7:0] sa_q, sub_q, tx_q, rx_q, tx_byte;
  logic [15:0] cnt_q;
  logic [1:0] qtr_q;
  logic [2:0] bit_q;
  logic       hold, start, q_end, b_end, y_end, sample, ack_st, data_st, bit_st;
`ifdef I2C_CLK_STRETCH_EN
  assign hold = qtr_q == 2'd1 && !scl_oe && !scl_i;
`else
  logic unused_scl_i;
  assign unused_scl_i = scl_i;
  assign hold = 1'b0;
`endif
  assign start  = i2c_addr[8] && !go_q && state_q == IDLE;
  assign q_end  = cnt_q == 16'(CLK_DIV - 1) && !hold;
  assign b_end  = q_end && qtr_q == 2'd3;
  assign y_end  = b_end && bit_q == 3'd7;
  assign sample = q_end && qtr_q == 2'd2;
  assign ack_st = state_q == ACK_A || state_q == ACK_S || state_q == ACK_W || state_q == ACK_R;
  assign data_st = state_q == ADDR || state_q == SUB || state_q == WDATA || state_q == RADDR;
  assign bit_st = data_st || ack_st || state_q == RDATA || state_q == MACK;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else state_q <= state_d;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
      qtr_q <= '0;
      bit_q <= '0;
    end else if (state_q == IDLE || state_q == DONE) begin
      cnt_q <= '0;
      qtr_q <= '0;
      bit_q <= '0;
    end else if (!hold) begin
      cnt_q <= q_end ? '0 : cnt_q + 16'd1;
      qtr_q <= q_end ? qtr_q + 2'd1 : qtr_q;
      bit_q <= !b_end ? bit_q : state_d != state_q ? 3'd0 : bit_q + 3'd1;
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      go_q   <= 1'b0;
      nack_q <= 1'b0;
      sa_q   <= '0;
      sub_q  <= '0;
      tx_q   <= '0;
      rx_q   <= '0;
    end else begin
      go_q <= i2c_addr[8];
      if (start) begin
        sa_q   <= slave_addr;
        sub_q  <= i2c_addr[7:0];
        tx_q   <= tx_data;
        nack_q <= 1'b0;
      end
      if (sample && ack_st && sda_i) nack_q <= 1'b1;
      if (sample && state_q == RDATA) rx_q <= {rx_q[6:0], sda_i};
    end
  end
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = start ? START : IDLE;
      START:   state_d = b_end ? ADDR : START;
      ADDR:    state_d = y_end ? ACK_A : ADDR;
      ACK_A:   state_d = !b_end ? ACK_A : nack_q ? STOP : SUB;
      SUB:     state_d = y_end ? ACK_S : SUB;
      ACK_S:   state_d = !b_end ? ACK_S : nack_q ? STOP : sa_q[0] ? RSTART : WDATA;
      WDATA:   state_d = y_end ? ACK_W : WDATA;
      ACK_W:   state_d = b_end ? STOP : ACK_W;
      RSTART:  state_d = b_end ? RADDR : RSTART;
      RADDR:   state_d = y_end ? ACK_R : RADDR;
      ACK_R:   state_d = !b_end ? ACK_R : nack_q ? STOP : RDATA;
      RDATA:   state_d = y_end ? MACK : RDATA;
      MACK:    state_d = b_end ? STOP : MACK;
      STOP:    state_d = b_end ? DONE : STOP;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  // Repeated START pulls SCL low in Q0 so the slave can release SDA before SCL rises.
  always_comb begin
    tx_byte = state_q == ADDR ? {sa_q[7:1], 1'b0} :
              state_q == SUB ? sub_q :
              state_q == WDATA ? tx_q : {sa_q[7:1], 1'b1};
    scl_oe = state_q == START ? qtr_q == 2'd3 :
             state_q == RSTART ? (qtr_q == 2'd3 || qtr_q == 2'd0) :
             state_q == STOP ? qtr_q == 2'd0 :
             bit_st && (qtr_q == 2'd0 || qtr_q == 2'd3);
    sda_oe = (state_q == START || state_q == RSTART) ? qtr_q[1] :
             state_q == STOP ? qtr_q != 2'd3 :
             data_st && !tx_byte[~bit_q];
    i2c_wr_en = state_q == DONE || (state_q == START && qtr_q == 2'd0 && cnt_q == '0);
    i2c_sts = {state_q != IDLE && state_q != DONE, nack_q};
    rx_data = (state_q == DONE && sa_q[0] && !nack_q) ? rx_q : tx_q;
  end
endmodule

// File: tb/tb_i2c_master_engine.sv
// tb_i2c_master_engine: randomized transactions against a behavioural I2C slave and transaction-level expectations.
module tb_i2c_master_engine;
  localparam int CLK_DIV = 4;
  localparam logic [6:0] SLV = 7'h1A;
  logic clk = 1'b0, rst = 1'b1;
  logic [7:0] slave_addr = '0, tx_data = '0, rx_data;
  logic [8:0] i2c_addr = '0;
  logic i2c_wr_en, scl_oe, sda_oe, scl_i, sda_i;
  logic [1:0] i2c_sts;
  int n_chk = 0, n_pass = 0, cyc = 0;
  int st_cyc[$];
  logic [1:0] st_sts[$];
  logic [7:0] st_rx[$];
  logic [7:0] got[$];
  logic [7:0] rdbyte = '0, cur = '0;
  bit stretch_req = 0, st_done = 0, first = 0, tmode = 0, rdm = 0, sel = 0, pull = 0;
  logic pscl = 1'b1, psda = 1'b1, poe = 1'b0, mack = 1'b0, scl, sda;
  int bitn = 0, st_cnt = 0, nstop = 0;

  i2c_master_engine #(.CLK_DIV(CLK_DIV)) dut (
    .clk(clk), .rst(rst), .slave_addr(slave_addr), .i2c_addr(i2c_addr), .tx_data(tx_data),
    .i2c_wr_en(i2c_wr_en), .i2c_sts(i2c_sts), .rx_data(rx_data),
    .scl_oe(scl_oe), .sda_oe(sda_oe), .scl_i(scl_i), .sda_i(sda_i)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;
  assign scl_i = !scl_oe && st_cnt == 0;
  assign sda_i = !(sda_oe || pull);

  always @(negedge clk) if (i2c_wr_en) begin
    st_cyc.push_back(cyc);
    st_sts.push_back(i2c_sts);
    st_rx.push_back(rx_data);
  end

  // Behavioural slave: acks its own address, serves rdbyte on reads, optionally stretches SUB's first SCL high phase.
  always @(negedge clk) begin
    if (rst) begin
      pull = 0; bitn = 0; st_cnt = 0; pscl = 1'b1; psda = 1'b1; poe = 1'b0;
    end else begin
      if (st_cnt > 0) st_cnt--;
      if (!stretch_req) st_done = 0;
      if (stretch_req && !st_done && !scl_oe && poe && got.size() > 0 && sel && bitn == 0 && !first && !tmode && cur[0] == 1'b0) begin
        st_cnt = 20;
        st_done = 1;
      end
      scl = !scl_oe && st_cnt == 0;
      sda = !(sda_oe || pull);
      if (scl && pscl && psda && !sda) begin
        bitn = 0; first = 1; tmode = 0; rdm = 0; sel = 0; pull = 0;
      end else if (scl && pscl && !psda && sda) begin
        nstop++;
      end else if (scl && !pscl) begin
        if (bitn < 8) begin
          cur = {cur[6:0], sda};
          bitn++;
        end else begin
          mack = sda;
          if (tmode && sda) rdm = 0;
          bitn = 9;
        end
      end else if (!scl && pscl) begin
        if (bitn == 9) begin
          bitn = 0;
          tmode = rdm;
        end
        if (bitn == 8) begin
          got.push_back(cur);
          if (first) begin
            sel = cur[7:1] == SLV;
            rdm = sel && cur[0];
            first = 0;
          end
          pull = !tmode && sel;
        end else begin
          pull = tmode && !rdbyte[7 - bitn];
        end
      end
      pscl = scl;
      psda = !(sda_oe || pull);
      poe = scl_oe;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic check_reset_outputs();
    check("rst_scl_oe", 32'(scl_oe), 0);
    check("rst_sda_oe", 32'(sda_oe), 0);
    check("rst_wr_en", 32'(i2c_wr_en), 0);
    check("rst_sts", 32'(i2c_sts), 0);
    check("rst_rx", 32'(rx_data), 0);
  endtask

  task automatic pulse_go(input logic [6:0] a, input logic rd, input logic [7:0] sub, input logic [7:0] tx);
    @(negedge clk);
    slave_addr = {a, rd};
    i2c_addr = {1'b0, sub};
    tx_data = tx;
    @(negedge clk);
    i2c_addr[8] = 1'b1;
    @(negedge clk);
    i2c_addr = {1'b0, 8'($urandom)};
    slave_addr = 8'($urandom);
    tx_data = 8'($urandom);
  endtask

  task automatic txn(input logic [6:0] a, input logic rd, input logic [7:0] sub, input logic [7:0] tx,
                     input logic [7:0] rdb, input int repulse, input bit stretch);
    logic match;
    logic [7:0] eb[$];
    int b0, g0, s0, lat;
    match = a == SLV;
    b0 = st_cyc.size();
    g0 = got.size();
    s0 = nstop;
    eb.push_back({a, 1'b0});
    if (match) begin
      eb.push_back(sub);
      if (rd) begin
        eb.push_back({a, 1'b1});
        eb.push_back(rdb);
      end else eb.push_back(tx);
    end
    lat = (match ? (rd ? 156 : 116) : 44) * CLK_DIV + (stretch ? 20 : 0);
    rdbyte = rdb;
    stretch_req = stretch;
    pulse_go(a, rd, sub, tx);
    for (int i = 0; i < lat + 100 && st_cyc.size() < b0 + 2; i++) begin
      @(negedge clk);
      if (repulse > 0 && i == repulse) i2c_addr[8] = 1'b1;
      if (repulse > 0 && i == repulse + 1) i2c_addr[8] = 1'b0;
    end
    repeat (40) @(negedge clk);
    check("strobe_count", 32'(st_cyc.size() - b0), 2);
    if (st_cyc.size() >= b0 + 2) begin
      check("start_sts", 32'(st_sts[b0]), 2);
      check("start_rx", 32'(st_rx[b0]), 32'(tx));
      check("latency", 32'(st_cyc[b0 + 1] - st_cyc[b0]), 32'(lat));
      check("done_sts", 32'(st_sts[b0 + 1]), match ? 0 : 1);
      check("done_rx", 32'(st_rx[b0 + 1]), 32'((match && rd) ? rdb : tx));
    end
    check("byte_count", 32'(got.size() - g0), 32'(eb.size()));
    for (int i = 0; i < eb.size() && g0 + i < got.size(); i++) check("bus_byte", 32'(got[g0 + i]), 32'(eb[i]));
    check("stop_count", 32'(nstop - s0), 1);
    if (match && rd) check("master_nack", 32'(mack), 1);
    check("lines_idle", 32'({scl_oe, sda_oe}), 0);
    stretch_req = 0;
  endtask

  initial begin
    int b0;
    logic [6:0] a;
    repeat (3) @(negedge clk);
    check_reset_outputs();
    rst = 1'b0;
    repeat (3) @(negedge clk);
    txn(SLV, 1'b0, 8'h02, 8'hA5, 8'h00, 0, 0);
    txn(SLV, 1'b1, 8'h10, 8'h77, 8'h5C, 0, 0);
    txn(7'h50, 1'b0, 8'h02, 8'h3C, 8'h00, 0, 0);
    txn(SLV, 1'b0, 8'h44, 8'h81, 8'h00, 50, 0);
    b0 = st_cyc.size();
    pulse_go(SLV, 1'b0, 8'h02, 8'hA5);
    repeat (197) @(negedge clk);
    rst = 1'b1;
    #1;
    check("rst_mid_scl", 32'(scl_oe), 0);
    check("rst_mid_sda", 32'(sda_oe), 0);
    repeat (5) @(negedge clk);
    i2c_addr = '0;
    rst = 1'b0;
    repeat (600) @(negedge clk);
    check("rst_strobes", 32'(st_cyc.size() - b0), 1);
    check_reset_outputs();
    txn(SLV, 1'b0, 8'h02, 8'hA5, 8'h00, 0, 0);
`ifdef I2C_CLK_STRETCH_EN
    txn(SLV, 1'b0, 8'h02, 8'hA5, 8'h00, 0, 1);
`endif
    for (int n = 0; n < 16; n++) begin
      a = ($urandom_range(0, 3) == 0) ? 7'($urandom) : SLV;
      txn(a, 1'($urandom), 8'($urandom), 8'($urandom), 8'($urandom), 0, 0);
    end
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
